// File: rtl/shot_resolver.sv
// shot_resolver: fires one shot per fire edge, flies it FLIGHT_CYCLES clocks, resolves hit/miss against the ship.
// Define SHOT_STREAK_EN to award a +3 bonus on every third consecutive hit.
module shot_resolver #(
  parameter logic [31:0] FLIGHT_CYCLES = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ship_state,
  input  logic [3:0]  aim,
  input  logic        fire,
  output logic [15:0] led_shot,
  output logic        hit,
  output logic        miss,
  output logic        bonus,
  output logic [7:0]  score,
  output logic [3:0]  ammo,
  output logic        busy,
  output logic        game_over
);
  typedef enum logic [1:0] {IDLE, FLIGHT, RESOLVE, OVER} state_t;
  state_t state, state_nx;
  logic fire_q, fire_edge, on_target;
  logic [3:0] shot_col;
  logic [31:0] count;
  logic [8:0] gain, sum;
  assign fire_edge = fire & ~fire_q;
  assign on_target = ship_state >= 4'd2 && shot_col >= ship_state - 4'd2 && shot_col <= ship_state;
  assign busy = state == FLIGHT || state == RESOLVE;
  assign game_over = state == OVER;
  assign led_shot = busy ? 16'd1 << shot_col : 16'h0000;
  assign sum = {1'b0, score} + gain;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = fire_edge && ammo != 4'd0 ? FLIGHT : IDLE;
      FLIGHT:  state_nx = count == FLIGHT_CYCLES - 32'd1 ? RESOLVE : FLIGHT;
      RESOLVE: state_nx = ammo == 4'd0 ? OVER : IDLE;
      default: state_nx = OVER;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fire_q <= 1'b0;
      shot_col <= 4'd0;
      count <= 32'd0;
      ammo <= 4'd15;
      score <= 8'd0;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      state <= state_nx;
      fire_q <= fire;
      hit <= state == RESOLVE && on_target;
      miss <= state == RESOLVE && !on_target;
      if (state == IDLE && state_nx == FLIGHT) begin
        shot_col <= aim;
        ammo <= ammo - 4'd1;
        count <= 32'd0;
      end else if (state == FLIGHT)
        count <= count + 32'd1;
      if (state == RESOLVE && on_target)
        score <= sum[8] ? 8'hff : sum[7:0];
    end
  end
`ifdef SHOT_STREAK_EN
  logic [1:0] streak;
  logic triple;
  assign triple = on_target && streak == 2'd2;
  assign gain = triple ? 9'd3 : 9'd1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= 2'd0;
      bonus <= 1'b0;
    end else begin
      bonus <= state == RESOLVE && triple;
      if (state == RESOLVE)
        streak <= on_target && !triple ? streak + 2'd1 : 2'd0;
    end
  end
`else
  assign gain = 9'd1;
  assign bonus = 1'b0;
`endif
endmodule

// File: tb/tb_shot_resolver.sv
// tb_shot_resolver: table-driven shots plus hand sequences for fire holding, game over and mid-flight reset.
module tb_shot_resolver;
  logic clk = 1'b0, rst, fire;
  logic [3:0] ship_state, aim, ammo;
  logic [15:0] led_shot;
  logic hit, miss, bonus, busy, game_over;
  logic [7:0] score;
  int n_vec = 0, n_fail = 0;
  int score_m = 0, ammo_m = 15, streak_m = 0;
  typedef struct {
    logic [3:0] aim;
    logic [3:0] ship_fly;
    logic [3:0] ship_res;
    logic       exp_hit;
  } vec_t;
  vec_t v[9];
  shot_resolver #(.FLIGHT_CYCLES(32'd4)) dut (
    .clk(clk), .rst(rst), .ship_state(ship_state), .aim(aim), .fire(fire),
    .led_shot(led_shot), .hit(hit), .miss(miss), .bonus(bonus), .score(score),
    .ammo(ammo), .busy(busy), .game_over(game_over)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model(input logic eh, output logic eb);
    eb = 1'b0;
    ammo_m--;
    if (!eh) streak_m = 0;
    else begin
`ifdef SHOT_STREAK_EN
      if (streak_m == 2) begin
        eb = 1'b1;
        streak_m = 0;
        score_m += 3;
      end else begin
        streak_m++;
        score_m++;
      end
`else
      score_m++;
`endif
      if (score_m > 255) score_m = 255;
    end
  endtask
  task automatic shot(input logic [3:0] a, input logic [3:0] sf, input logic [3:0] sr,
                      input logic eh, input string nm);
    logic eb;
    model(eh, eb);
    @(negedge clk);
    aim = a;
    ship_state = sf;
    fire = 1'b1;
    @(negedge clk);
    chk({nm, "_busy"}, 16'(busy), 16'd1);
    chk({nm, "_led"}, led_shot, 16'd1 << a);
    fire = 1'b0;
    repeat (3) @(negedge clk);
    ship_state = sr;
    @(negedge clk);
    chk({nm, "_res_busy"}, 16'(busy), 16'd1);
    chk({nm, "_early"}, 16'({hit, miss}), 16'd0);
    @(negedge clk);
    chk({nm, "_hit"}, 16'(hit), 16'(eh));
    chk({nm, "_miss"}, 16'(miss), 16'(!eh));
    chk({nm, "_bonus"}, 16'(bonus), 16'(eb));
    chk({nm, "_score"}, 16'(score), 16'(score_m));
    chk({nm, "_ammo"}, 16'(ammo), 16'(ammo_m));
    chk({nm, "_idle"}, {15'd0, busy}, 16'd0);
    @(negedge clk);
    chk({nm, "_pulse_end"}, 16'({hit, miss, bonus}), 16'd0);
  endtask
  initial begin
    logic eb;
    v[0] = '{4'd5, 4'd6, 4'd6, 1'b1};
    v[1] = '{4'd2, 4'd3, 4'd10, 1'b0};
    v[2] = '{4'd0, 4'd1, 4'd1, 1'b0};
    v[3] = '{4'd15, 4'd15, 4'd15, 1'b1};
    v[4] = '{4'd13, 4'd15, 4'd15, 1'b1};
    v[5] = '{4'd12, 4'd15, 4'd15, 1'b0};
    v[6] = '{4'd0, 4'd2, 4'd2, 1'b1};
    v[7] = '{4'd4, 4'd5, 4'd5, 1'b1};
    v[8] = '{4'd3, 4'd3, 4'd3, 1'b1};
    rst = 1'b0;
    fire = 1'b0;
    aim = 4'd0;
    ship_state = 4'd0;
    #12;
    chk("rst_ammo", 16'(ammo), 16'd15);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_led", led_shot, 16'd0);
    chk("rst_flags", 16'({hit, miss, bonus, busy, game_over}), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++)
      shot(v[i].aim, v[i].ship_fly, v[i].ship_res, v[i].exp_hit, $sformatf("v%0d", i));
`ifdef SHOT_STREAK_EN
    chk("streak_score", 16'(score), 16'd8);
`else
    chk("streak_score", 16'(score), 16'd6);
`endif
    model(1'b0, eb);
    @(negedge clk);
    aim = 4'd7;
    ship_state = 4'd0;
    fire = 1'b1;
    @(negedge clk);
    chk("hold_busy", 16'(busy), 16'd1);
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
    fire = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold_res_busy", 16'(busy), 16'd1);
    @(negedge clk);
    chk("hold_miss", 16'(miss), 16'd1);
    chk("hold_ammo", 16'(ammo), 16'(ammo_m));
    repeat (4) @(negedge clk);
    chk("hold_no_refire", 16'(busy), 16'd0);
    chk("hold_ammo_kept", 16'(ammo), 16'(ammo_m));
    fire = 1'b0;
    for (int i = 0; i < 5; i++)
      shot(4'(i), 4'd12, 4'd12, 1'b0, $sformatf("drain%0d", i));
    chk("over_flag", 16'(game_over), 16'd1);
    chk("over_ammo", 16'(ammo), 16'd0);
    @(negedge clk);
    fire = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("over_ignored", 16'({busy, hit, miss, led_shot != 16'd0}), 16'd0);
    end
    chk("over_stays", 16'(game_over), 16'd1);
    fire = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rerst_ammo", 16'(ammo), 16'd15);
    chk("rerst_score", 16'(score), 16'd0);
    chk("rerst_over", 16'(game_over), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    score_m = 0;
    ammo_m = 15;
    streak_m = 0;
    @(negedge clk);
    aim = 4'd9;
    ship_state = 4'd9;
    fire = 1'b1;
    @(negedge clk);
    chk("abort_busy", 16'(busy), 16'd1);
    fire = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_led", led_shot, 16'd0);
    chk("abort_idle", 16'(busy), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_pulse", 16'({hit, miss, busy}), 16'd0);
    end
    chk("abort_ammo", 16'(ammo), 16'd15);
    shot(4'd9, 4'd9, 4'd10, 1'b1, "after_abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
